adc0809_emu: RTL and testbench

- Synthesizable emulator of the ADC0809 converter, i.e. the responder side of the ADC start/eoc/oe handshake.
- Lets the acquisition chain (ADC controller → FIFO → UART TX) be brought up and self-tested in-system without the physical converter.
- Sits between the ADC controller's outputs and its `eoc`/`data_in` inputs; a board-level mux selects real ADC or emulator.
- Produces deterministic sample patterns (external, ramp, pseudo-random, constant) with datasheet-like eoc timing.

---
 rtl/adc0809_emu.sv | 263 ++++++++++++++++++++++++++
 tb/tb_adc0809_emu.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc0809_emu.sv
// adc0809_emu: synchronous stand-in for an ADC0809 converter. It answers the
// controller's start/eoc/oe handshake with datasheet-like eoc timing and
// produces deterministic samples (external, ramp, LFSR, constant).
// The board mux chooses between the real converter and this block.
// Optional feature macro: ADC_EMU_LFSR_EN. It enables the LFSR source for
// mode 2'b10. Without it, mode 2'b10 produces the ramp instead.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | eoc=1, busy=0, waiting for start to rise
// ARMED   | eoc=1, busy=1, SAR held in reset, waiting for start to fall
// DELAY   | eoc=1, busy=1, counting EOC_DLY adc_clk rises
// CONV    | eoc=0, busy=1, counting CONV_CLKS adc_clk rises
// DONE    | eoc=1, busy=0, result published for one clk, then IDLE

module adc0809_emu #(
    parameter int unsigned CONV_CLKS = 64,
    parameter int unsigned EOC_DLY   = 8,
    parameter int unsigned RAMP_STEP = 1,
    parameter logic [7:0]  LFSR_SEED = 8'hB8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        adc_clk,
    input  logic        start,
    input  logic        oe,
    input  logic [1:0]  mode,
    input  logic [7:0]  ext_sample,
    output logic        eoc,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic        busy,
    output logic [15:0] conv_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_DELAY,
        S_CONV,
        S_DONE
    } state_t;

    localparam logic [7:0] DLY_LOAD  = 8'(EOC_DLY - 1);
    localparam logic [7:0] CONV_LOAD = 8'(CONV_CLKS - 1);
    localparam logic [7:0] STEP      = 8'(RAMP_STEP);
    localparam logic [7:0] CONST_VAL = 8'hA5;

    // Bit 0 and bit 1 form the synchronizer; bit 2 is the previous value.
    logic [2:0] adc_sh;
    logic [2:0] start_sh;
    logic [2:0] oe_sh;

    logic       adc_rise;
    logic       start_rise;
    logic       start_fall;
    logic       oe_sync;

    state_t     state;
    state_t     state_nxt;

    logic [7:0] tmr;
    logic       tmr_tc;
    logic       tmr_load_dly;
    logic       tmr_load_conv;
    logic       tmr_dec;

    logic       capture;
    logic       done_evt;
    logic       eoc_nxt;
    logic       busy_nxt;

    logic [7:0] pending;
    logic [7:0] result;
    logic [7:0] ramp;
    logic [7:0] sample_sel;

`ifdef ADC_EMU_LFSR_EN
    logic [7:0] lfsr;
    logic       lfsr_fb;
`endif

    // Bring the three controller pins into clk; the extra stage provides edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            adc_sh   <= 3'b000;
            start_sh <= 3'b000;
            oe_sh    <= 3'b000;
        end else begin
            adc_sh   <= {adc_sh[1:0], adc_clk};
            start_sh <= {start_sh[1:0], start};
            oe_sh    <= {oe_sh[1:0], oe};
        end
    end

    assign adc_rise   = adc_sh[1] & ~adc_sh[2];
    assign start_rise = start_sh[1] & ~start_sh[2];
    assign start_fall = ~start_sh[1] & start_sh[2];
    assign oe_sync    = oe_sh[1];
    assign tmr_tc     = (tmr == 8'h00);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and timer and datapath strobes. A start rise aborts from any busy state.
    always_comb begin
        state_nxt     = state;
        capture       = 1'b0;
        done_evt      = 1'b0;
        tmr_load_dly  = 1'b0;
        tmr_load_conv = 1'b0;
        tmr_dec       = 1'b0;
        eoc_nxt       = 1'b1;
        busy_nxt      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_rise) begin
                    state_nxt = S_ARMED;
                end
            end
            S_ARMED: begin
                // An adc_clk rise in the same clk as start falling is deliberately dropped.
                if (start_fall) begin
                    capture      = 1'b1;
                    tmr_load_dly = 1'b1;
                    state_nxt    = S_DELAY;
                end
            end
            S_DELAY: begin
                if (start_rise) begin
                    state_nxt = S_ARMED;
                end else if (adc_rise) begin
                    if (tmr_tc) begin
                        tmr_load_conv = 1'b1;
                        state_nxt     = S_CONV;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
            end
            S_CONV: begin
                if (start_rise) begin
                    state_nxt = S_ARMED;
                end else if (adc_rise) begin
                    if (tmr_tc) begin
                        done_evt  = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_nxt = start_rise ? S_ARMED : S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state, so they change in the same clk as the state.
        case (state_nxt)
            S_ARMED, S_DELAY: busy_nxt = 1'b1;
            S_CONV: begin
                busy_nxt = 1'b1;
                eoc_nxt  = 1'b0;
            end
            default: begin
                busy_nxt = 1'b0;
                eoc_nxt  = 1'b1;
            end
        endcase
    end

    // Registered handshake outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            eoc  <= 1'b1;
            busy <= 1'b0;
        end else begin
            eoc  <= eoc_nxt;
            busy <= busy_nxt;
        end
    end

    // Down-counter shared by the DELAY and CONV phases. The terminal count is zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmr <= 8'h00;
        end else if (tmr_load_dly) begin
            tmr <= DLY_LOAD;
        end else if (tmr_load_conv) begin
            tmr <= CONV_LOAD;
        end else if (tmr_dec) begin
            tmr <= tmr - 8'd1;
        end
    end

    // Sample source select. Mode is only used at the capture strobe.
    always_comb begin
        sample_sel = 8'h00;
        case (mode)
            2'b00:   sample_sel = ext_sample;
            2'b01:   sample_sel = ramp;
`ifdef ADC_EMU_LFSR_EN
            2'b10:   sample_sel = lfsr;
`else
            2'b10:   sample_sel = ramp;
`endif
            default: sample_sel = CONST_VAL;
        endcase
    end

    // Capture at start fall. A completed conversion publishes the result and advances the generators.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending    <= 8'h00;
            result     <= 8'h00;
            ramp       <= 8'h00;
            conv_count <= 16'h0000;
        end else begin
            if (capture) begin
                pending <= sample_sel;
            end
            if (done_evt) begin
                result     <= pending;
                ramp       <= ramp + STEP;
                conv_count <= conv_count + 16'd1;
            end
        end
    end

`ifdef ADC_EMU_LFSR_EN
    // Fibonacci LFSR x^8+x^6+x^5+x^4+1, shifting left, stepping once per completed conversion.
    assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr <= LFSR_SEED;
        end else if (done_evt) begin
            lfsr <= {lfsr[6:0], lfsr_fb};
        end
    end
`endif

    // Emulated tri-state bus. It follows the synchronized oe regardless of FSM state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_oe  <= 1'b0;
            data_out <= 8'h00;
        end else begin
            data_oe  <= oe_sync;
            data_out <= oe_sync ? result : 8'h00;
        end
    end

endmodule

// File: tb/tb_adc0809_emu.sv
// Directed bench for adc0809_emu. u_slow uses the default timing; u_fast uses
// short timing so that the long ramp and LFSR sequences stay brief.
module tb_adc0809_emu;

    logic        clk;
    logic        reset_n;
    logic        adc_clk;
    logic        start;
    logic        oe;
    logic [1:0]  mode;
    logic [7:0]  ext_sample;

    logic        s_eoc, f_eoc;
    logic [7:0]  s_data_out, f_data_out;
    logic        s_data_oe, f_data_oe;
    logic        s_busy, f_busy;
    logic [15:0] s_conv_count, f_conv_count;

    int          n_tests;
    int          n_fail;
    int          rise_cnt;
    int          r0;
    logic [7:0]  rd_s, rd_f;
    logic        rd_oe_s, rd_oe_f;
    logic [7:0]  lfsr_exp [3];

    adc0809_emu u_slow (
        .clk        (clk),
        .reset_n    (reset_n),
        .adc_clk    (adc_clk),
        .start      (start),
        .oe         (oe),
        .mode       (mode),
        .ext_sample (ext_sample),
        .eoc        (s_eoc),
        .data_out   (s_data_out),
        .data_oe    (s_data_oe),
        .busy       (s_busy),
        .conv_count (s_conv_count)
    );

    adc0809_emu #(.CONV_CLKS(2), .EOC_DLY(1)) u_fast (
        .clk        (clk),
        .reset_n    (reset_n),
        .adc_clk    (adc_clk),
        .start      (start),
        .oe         (oe),
        .mode       (mode),
        .ext_sample (ext_sample),
        .eoc        (f_eoc),
        .data_out   (f_data_out),
        .data_oe    (f_data_oe),
        .busy       (f_busy),
        .conv_count (f_conv_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // adc_clk runs 4 clk per phase. Its edges fall 2 ns after the clk negedges.
    initial begin
        adc_clk = 1'b0;
        #2;
        forever #40 adc_clk = ~adc_clk;
    end

    initial rise_cnt = 0;
    always @(posedge adc_clk) rise_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_eoc(input bit fast, input logic lvl, input int budget, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (((fast ? f_eoc : s_eoc) !== lvl) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < budget), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic raise_start();
        @(posedge clk);
        #1 start = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    // Drop start one clk after an adc_clk rise, so the next counted rise is a full period away.
    task automatic drop_start_aligned();
        @(posedge adc_clk);
        @(posedge clk);
        #1 start = 1'b0;
        r0 = rise_cnt;
    endtask

    task automatic conv_fast();
        raise_start();
        #1 start = 1'b0;
        wait_eoc(1'b1, 1'b0, 200, "f_eoc_fall_wait");
        wait_eoc(1'b1, 1'b1, 200, "f_eoc_rise_wait");
    endtask

    task automatic read_bus();
        @(posedge clk);
        #1 oe = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rd_s    = s_data_out;
        rd_f    = f_data_out;
        rd_oe_s = s_data_oe;
        rd_oe_f = f_data_oe;
        oe = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int n;
        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        start   = 1'b0;
        oe      = 1'b0;
        mode    = 2'b11;
        ext_sample = 8'h00;
`ifdef ADC_EMU_LFSR_EN
        lfsr_exp = '{8'hB8, 8'h70, 8'hE0};
`else
        lfsr_exp = '{8'h00, 8'h01, 8'h02};
`endif
        #13;
        check("rst_eoc", 32'(s_eoc), 32'd1);
        check("rst_busy", 32'(s_busy), 32'd0);
        check("rst_data_out", 32'(s_data_out), 32'h00);
        check("rst_data_oe", 32'(s_data_oe), 32'd0);
        check("rst_conv_count", 32'(s_conv_count), 32'd0);
        do_reset();

        // Constant source, default timing
        mode = 2'b11;
        raise_start();
        check("t1_armed_busy", 32'(s_busy), 32'd1);
        check("t1_armed_eoc", 32'(s_eoc), 32'd1);
        drop_start_aligned();
        wait_eoc(1'b0, 1'b0, 2000, "t1_eoc_fall_wait");
        check("t1_dly_rises", 32'(rise_cnt - r0), 32'd8);
        check("t1_busy_conv", 32'(s_busy), 32'd1);
        r0 = rise_cnt;
        wait_eoc(1'b0, 1'b1, 2000, "t1_eoc_rise_wait");
        check("t1_conv_rises", 32'(rise_cnt - r0), 32'd64);
        check("t1_busy_done", 32'(s_busy), 32'd0);
        read_bus();
        check("t1_data", 32'(rd_s), 32'hA5);
        check("t1_data_oe", 32'(rd_oe_s), 32'd1);
        check("t1_count", 32'(s_conv_count), 32'd1);
        check("t1_bus_released", 32'(s_data_out), 32'h00);

        // Ramp source: 258 conversions, with the ramp wrapping at 256
        do_reset();
        mode = 2'b01;
        for (int i = 0; i < 258; i++) begin
            conv_fast();
            read_bus();
            check("ramp_data", 32'(rd_f), 32'(i % 256));
        end
        check("ramp_count", 32'(f_conv_count), 32'd258);
        check("ramp_data_oe", 32'(rd_oe_f), 32'd1);

        // LFSR source, or the ramp when the LFSR feature is not built
        do_reset();
        mode = 2'b10;
        for (int i = 0; i < 3; i++) begin
            conv_fast();
            read_bus();
            check("lfsr_data", 32'(rd_f), 32'(lfsr_exp[i]));
        end
        check("lfsr_count", 32'(f_conv_count), 32'd3);

        // Abort mid-CONV, restart, and change mode during the conversion
        do_reset();
        mode = 2'b00;
        ext_sample = 8'h3C;
        raise_start();
        drop_start_aligned();
        wait_eoc(1'b0, 1'b0, 2000, "ab_eoc_fall_wait");
        r0 = rise_cnt;
        n = 0;
        while ((rise_cnt < r0 + 20) && (n < 1000)) begin
            @(negedge clk);
            n++;
        end
        check("ab_rise_wait", 32'(n < 1000), 32'd1);
        @(posedge clk);
        #1 start = 1'b1;
        repeat (3) @(negedge clk);
        check("ab_eoc_before", 32'(s_eoc), 32'd0);
        @(negedge clk);
        check("ab_eoc_high", 32'(s_eoc), 32'd1);
        check("ab_busy", 32'(s_busy), 32'd1);
        check("ab_count_hold", 32'(s_conv_count), 32'd0);
        repeat (2) @(posedge clk);
        drop_start_aligned();
        wait_eoc(1'b0, 1'b0, 2000, "ab_eoc_fall2_wait");
        mode = 2'b01;
        ext_sample = 8'h77;
        wait_eoc(1'b0, 1'b1, 2000, "ab_eoc_rise_wait");
        read_bus();
        check("ab_data", 32'(rd_s), 32'h3C);
        check("ab_count", 32'(s_conv_count), 32'd1);

        // oe behaviour during CONV, then an asynchronous reset mid-CONV
        mode = 2'b11;
        raise_start();
        drop_start_aligned();
        wait_eoc(1'b0, 1'b0, 2000, "oe_eoc_fall_wait");
        repeat (6) @(negedge clk);
        check("oe_low_data", 32'(s_data_out), 32'h00);
        check("oe_low_oe", 32'(s_data_oe), 32'd0);
        read_bus();
        check("oe_conv_prev", 32'(rd_s), 32'h3C);
        check("oe_conv_oe", 32'(rd_oe_s), 32'd1);
        check("oe_still_conv", 32'(s_eoc), 32'd0);
        @(posedge clk);
        #1 oe = 1'b1;
        repeat (4) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rr_eoc", 32'(s_eoc), 32'd1);
        check("rr_busy", 32'(s_busy), 32'd0);
        check("rr_data_out", 32'(s_data_out), 32'h00);
        check("rr_data_oe", 32'(s_data_oe), 32'd0);
        check("rr_count", 32'(s_conv_count), 32'd0);
        oe = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rr_idle_eoc", 32'(s_eoc), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
